// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: one-hot registered grant, address/data-phase owner
// tracking and a per-tenure beat quota that only bites between bursts.
module ahb_arbiter #(
  parameter int N_MST       = 4,
  parameter int DEFAULT_MST = 0,
  parameter int MAX_BEATS   = 16
) (
  input  logic             hclk_i,
  input  logic             irst,
  input  logic [N_MST-1:0] hbusreq_i,
  input  logic [1:0]       htrans_i,
  input  logic             hready_i,
  output logic [N_MST-1:0] hgrant_o,
  output logic [1:0]       hmaster_o,
  output logic [1:0]       hmaster_data_o,
  output logic             arb_busy_o
);

  localparam int             CW         = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]  BEAT_MAX   = CW'(MAX_BEATS);
  localparam logic [1:0]     DEF_IDX    = 2'(DEFAULT_MST);
  localparam logic [1:0]     HTRANS_SEQ = 2'b11;

  typedef enum logic {PARK, OWN} state_t;

  state_t           state;
  logic [CW-1:0]    beat_cnt;
  logic [1:0]       last_owner;
  logic [1:0]       winner;
  logic [N_MST-1:0] owner_mask;
  logic             any_req;
  logic             owner_req;
  logic             others_req;
  logic             quota_hit;
  logic             release_own;

  function automatic logic [N_MST-1:0] idx_to_onehot(input logic [1:0] idx);
    return N_MST'(1) << idx;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [N_MST-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  // Walk downward so the nearest requester after 'last' wins; k == N_MST is 'last' itself.
  function automatic logic [1:0] rr_pick(input logic [N_MST-1:0] req, input logic [1:0] last);
    logic [1:0]       pick;
    logic [N_MST-1:0] rot;
    int               cand;
    pick = last;
    for (int k = N_MST; k >= 1; k--) begin
      cand = (int'(last) + k) % N_MST;
      rot  = req >> cand;
      if (rot[0]) pick = cand[1:0];
    end
    return pick;
  endfunction

  always_comb begin
    owner_mask  = idx_to_onehot(last_owner);
    any_req     = |hbusreq_i;
    owner_req   = |(hbusreq_i & owner_mask);
    others_req  = |(hbusreq_i & ~owner_mask);
    quota_hit   = (beat_cnt == BEAT_MAX) && others_req && (htrans_i != HTRANS_SEQ);
    release_own = !owner_req || quota_hit;
    winner      = rr_pick(hbusreq_i, last_owner);
  end

  always_ff @(posedge hclk_i) begin
    if (irst) begin
      state          <= PARK;
      beat_cnt       <= '0;
      last_owner     <= DEF_IDX;
      hgrant_o       <= idx_to_onehot(DEF_IDX);
      hmaster_o      <= DEF_IDX;
      hmaster_data_o <= DEF_IDX;
    end else if (hready_i) begin
      hmaster_o      <= onehot_to_idx(hgrant_o);
      hmaster_data_o <= hmaster_o;
      case (state)
        PARK: begin
          beat_cnt <= '0;
          if (any_req) begin
            state      <= OWN;
            hgrant_o   <= idx_to_onehot(winner);
            last_owner <= winner;
          end else begin
            hgrant_o   <= idx_to_onehot(DEF_IDX);
          end
        end
        OWN: begin
          if (release_own) begin
            beat_cnt <= '0;
            if (any_req) begin
              hgrant_o   <= idx_to_onehot(winner);
              last_owner <= winner;
            end else begin
              state      <= PARK;
              hgrant_o   <= idx_to_onehot(DEF_IDX);
            end
          end else if (htrans_i[1] && (beat_cnt != BEAT_MAX)) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= PARK;
      endcase
    end
  end

  assign arb_busy_o = (state == OWN) && (hmaster_o != DEF_IDX);

  grant_onehot: assert property (@(posedge hclk_i) disable iff (irst) $onehot(hgrant_o));

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: parking, handover lag, round-robin order,
// beat quota with and without SEQ bursts, stall freeze and mid-tenure reset.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic       hclk;
  logic       irst;
  logic [3:0] hbusreq;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;
  logic       arb_busy;

  int checks = 0;
  int errors = 0;

  ahb_arbiter #(.N_MST(4), .DEFAULT_MST(0), .MAX_BEATS(16)) dut (
    .hclk_i         (hclk),
    .irst           (irst),
    .hbusreq_i      (hbusreq),
    .htrans_i       (htrans),
    .hready_i       (hready),
    .hgrant_o       (hgrant),
    .hmaster_o      (hmaster),
    .hmaster_data_o (hmaster_data),
    .arb_busy_o     (arb_busy)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] m,
                         input logic [1:0] d, input logic b);
    chk({tag, "_grant"}, 32'(hgrant), 32'(g));
    chk({tag, "_hmaster"}, 32'(hmaster), 32'(m));
    chk({tag, "_hmaster_data"}, 32'(hmaster_data), 32'(d));
    chk({tag, "_busy"}, 32'(arb_busy), 32'(b));
  endtask

  int         order [5] = '{1, 2, 3, 0, 1};
  logic [3:0] mask;

  initial begin
    irst    = 1'b1;
    hbusreq = 4'b0000;
    htrans  = IDLE;
    hready  = 1'b1;

    // reset and idle parking
    tick();
    tick();
    chk_all("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    irst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("park_idle", 4'b0001, 2'd0, 2'd0, 1'b0);
    end

    // single requester: grant, then address and data owner lag one ready cycle each
    hbusreq = 4'b0100;
    tick();
    chk_all("req2_e1", 4'b0100, 2'd0, 2'd0, 1'b0);
    tick();
    chk_all("req2_e2", 4'b0100, 2'd2, 2'd0, 1'b1);
    tick();
    chk_all("req2_e3", 4'b0100, 2'd2, 2'd2, 1'b1);
    hbusreq = 4'b0000;
    tick();
    chk_all("rel2_e1", 4'b0001, 2'd2, 2'd2, 1'b0);
    tick();
    chk_all("rel2_e2", 4'b0001, 2'd0, 2'd2, 1'b0);
    tick();
    chk_all("rel2_e3", 4'b0001, 2'd0, 2'd0, 1'b0);

    // round robin with INCR4 bursts, starting from last_owner = 0
    irst = 1'b1;
    tick();
    chk("rr_reset_grant", 32'(hgrant), 32'h1);
    irst    = 1'b0;
    hbusreq = 4'b1111;
    htrans  = IDLE;
    tick();
    chk("rr_first", 32'(hgrant), 32'h2);
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) begin
        htrans = (b == 0) ? NONSEQ : SEQ;
        tick();
        chk("rr_hold", 32'(hgrant), 32'(1) << order[i]);
      end
      mask    = 4'b0001 << order[i];
      hbusreq = ~mask;
      htrans  = IDLE;
      tick();
      chk("rr_next", 32'(hgrant), 32'(1) << order[i+1]);
      hbusreq = 4'b1111;
    end

    // quota with NONSEQ singles: master 1 owns, master 3 waits
    irst = 1'b1;
    tick();
    irst    = 1'b0;
    hbusreq = 4'b0010;
    htrans  = NONSEQ;
    tick();
    chk("q_grant1", 32'(hgrant), 32'h2);
    hbusreq = 4'b1010;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("q_hold1", 32'(hgrant), 32'h2);
    end
    tick();
    chk("q_switch3", 32'(hgrant), 32'h8);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("q_hold3", 32'(hgrant), 32'h8);
    end
    tick();
    chk("q_back1", 32'(hgrant), 32'h2);

    // quota reached inside a SEQ burst: held until the next NONSEQ
    htrans = NONSEQ;
    tick();
    chk("qs_beat1", 32'(hgrant), 32'h2);
    htrans = SEQ;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("qs_to16", 32'(hgrant), 32'h2);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("qs_past16", 32'(hgrant), 32'h2);
    end
    htrans = NONSEQ;
    tick();
    chk("qs_switch", 32'(hgrant), 32'h8);

    // stall freeze
    htrans  = IDLE;
    hbusreq = 4'b1000;
    tick();
    chk_all("pre_stall1", 4'b1000, 2'd3, 2'd1, 1'b1);
    tick();
    chk_all("pre_stall2", 4'b1000, 2'd3, 2'd3, 1'b1);
    hready  = 1'b0;
    hbusreq = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("stall", 4'b1000, 2'd3, 2'd3, 1'b1);
    end
    hready = 1'b1;
    tick();
    chk_all("unstall1", 4'b0100, 2'd3, 2'd3, 1'b1);
    tick();
    chk_all("unstall2", 4'b0100, 2'd2, 2'd3, 1'b1);

    // reset mid-tenure
    irst = 1'b1;
    tick();
    chk_all("mid_reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    irst    = 1'b0;
    hbusreq = 4'b0000;
    tick();
    chk_all("post_reset", 4'b0001, 2'd0, 2'd0, 1'b0);

    // default master requests while parked: same grant, then it keeps the bus
    hbusreq = 4'b0001;
    tick();
    chk_all("def_own", 4'b0001, 2'd0, 2'd0, 1'b0);
    hbusreq = 4'b0101;
    tick();
    chk("def_keeps", 32'(hgrant), 32'h1);
    hbusreq = 4'b0100;
    tick();
    chk("def_release", 32'(hgrant), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter for up to 4 ahb_master-style requesters sharing one AHB address/data bus.
- Samples hbusreq from each master and drives a one-hot hgrant.
- Drives hmaster (address-phase owner) and hmaster_data (data-phase owner), which select the shared haddr/htrans/hwrite/hwdata muxes.
- Applies a beat quota so one master cannot hold the bus while others wait.

Parameters:
- N_MST, 4, number of masters (2..4).
- DEFAULT_MST, 0, master parked on the bus when nobody requests.
- MAX_BEATS, 16, quota of NONSEQ/SEQ beats per tenure before forced re-arbitration when another master is requesting.

Ports:
- hclk_i  in  1  bus clock; all state changes on rising edge.
- irst  in  1  synchronous reset, active-high.
- hbusreq_i  in  N_MST  per-master bus request.
- htrans_i  in  2  muxed htrans from the current address-phase owner.
- hready_i  in  1  bus ready; arbitration happens only when hready_i=1.
- hgrant_o  out  N_MST  one-hot grant, registered.
- hmaster_o  out  2  index of the address-phase owner.
- hmaster_data_o  out  2  index of the data-phase owner.
- arb_busy_o  out  1  1 while any master other than the parked default holds the grant.

Behaviour:
- Reset (irst=1 at clock edge) forces:
  - hgrant_o = 1<<DEFAULT_MST
  - hmaster_o = hmaster_data_o = DEFAULT_MST
  - state = PARK, beat_cnt = 0, last_owner = DEFAULT_MST, arb_busy_o = 0
  - A reset mid-tenure discards the ownership immediately; no burst completion.
- The FSM has two states, PARK and OWN. Arbitration point = rising edge with hready_i=1. With hready_i=0, hgrant_o, hmaster_o, hmaster_data_o, state and beat_cnt all hold.
- PARK:
  - No request → stay in PARK, grant stays on DEFAULT_MST.
  - Any hbusreq_i bit set → choose winner by round-robin, go to OWN, hgrant_o = one-hot(winner).
- OWN, at an arbitration point, the grant is released when either:
  - the owner's hbusreq_i bit = 0 (release), or
  - quota expired: beat_cnt = MAX_BEATS, another master is requesting, and htrans_i ≠ SEQ.
- On release:
  - Some request pending → new winner by round-robin, stay in OWN.
  - No request pending → go to PARK, grant = DEFAULT_MST.
- Round-robin search:
  - Starts at last_owner+1 and wraps modulo N_MST; the first requesting index wins.
  - The current owner is searched last, so it wins only when it is the sole requester.
  - last_owner updates to the winner on every grant change.
- hmaster_o: at each arbitration point it is loaded with the index encoded in hgrant_o. It therefore lags the grant by one ready cycle, per the AHB address-phase handover.
- hmaster_data_o: at each arbitration point it is loaded with hmaster_o, one further ready cycle behind.
- beat_cnt:
  - Width holds 0..MAX_BEATS and saturates at MAX_BEATS.
  - Increments when hready_i=1 and htrans_i[1]=1 (NONSEQ/SEQ) and state=OWN.
  - Clears to 0 on every grant change and in PARK.
  - htrans_i BUSY/IDLE beats do not count.
- Quota is never enforced mid-burst: with htrans_i=SEQ the owner keeps the grant even past MAX_BEATS. The switch happens at the first ready cycle with NONSEQ/IDLE/BUSY.
- Simultaneous owner release and new requests → new winner granted in the same arbitration point; no idle gap cycle.
- A master requesting while already parked-granted (DEFAULT_MST) → enters OWN with the same grant vector; hgrant_o does not glitch.
- arb_busy_o = (state==OWN) & (hmaster_o ≠ DEFAULT_MST), combinational from registers.
- hgrant_o is always exactly one-hot; an assertion checks $onehot(hgrant_o) every cycle after reset.

Test Plan:
- Reset, no requests, hready_i=1 for 10 cycles → hgrant_o=4'b0001, hmaster_o=0, hmaster_data_o=0, arb_busy_o=0 throughout.
- hbusreq_i=4'b0100 at cycle 5, hready_i=1 → hgrant_o=4'b0100 after edge 5, hmaster_o=2 after edge 6, hmaster_data_o=2 after edge 7, arb_busy_o=1 from edge 6.
- All four requesting continuously, each doing 4-beat INCR4 (NONSEQ,SEQ,SEQ,SEQ) then dropping req for one cycle → grant order 1,2,3,0,1 starting from last_owner=0; no master granted twice in a row.
- Master 1 holds hbusreq with 20 back-to-back NONSEQ singles, master 3 requests → grant moves to master 3 at the ready edge after beat 16; beat_cnt back to 0.
- Quota expiry on beat 16 while htrans_i=SEQ for 3 more beats, then NONSEQ → grant held through the SEQ beats and switches at the NONSEQ ready edge.
- hready_i=0 for 5 cycles while the owner drops req and master 2 requests → all outputs frozen during the stall. First hready_i=1 edge grants master 2. irst pulse mid-tenure → outputs return to the reset values next edge.
